pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 18 +
 rtl/add_slice.sv | 25 ++
 rtl/pipe_adder.sv | 116 +++++++++++
 tb/tb_pipe_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and stage-register record for the chunked pipelined adder.
// Records are sized for the widest supported operand; narrower adders use the low bits.
package pipe_adder_pkg;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultStages = 4;
    localparam int unsigned MaxWidth      = 64;

    typedef struct packed {
        logic                valid;
        logic                carry;
        logic [MaxWidth-1:0] sum;
        logic [MaxWidth-1:0] a;
        logic [MaxWidth-1:0] b;
        logic                sub;
    } stage_t;

endpackage

// File: rtl/add_slice.sv
// CHUNK-bit ripple adder slice used by each pipeline stage.
module add_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co = carry[CHUNK];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered between
// stages, valid/ready handshake with bubble-collapsing stage advance.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 2 || WIDTH > MaxWidth || (WIDTH % STAGES) != 0) begin : gen_bad_cfg
        $error("pipe_adder: WIDTH must be in 2..MaxWidth and divisible by STAGES");
    end

    function automatic stage_t merge_chunk(input stage_t in, input logic [CHUNK-1:0] chunk,
                                           input logic co, input int unsigned idx);
        stage_t out;
        out                          = in;
        out.sum[idx*CHUNK +: CHUNK] = chunk;
        out.carry                    = co;
        return out;
    endfunction

    stage_t            st_q [STAGES];
    stage_t            res  [STAGES];
    logic [STAGES-1:0] adv;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        stage_t           src;
        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic [CHUNK-1:0] sum_chunk;
        logic             co;

        // Stage 0 adds directly from the ports so the accepting edge captures chunk 0.
        if (k == 0) begin : gen_src_in
            assign src = '{valid: in_valid,
                           carry: sub ? 1'b1 : cin,
                           sum:   '0,
                           a:     MaxWidth'(a),
                           b:     MaxWidth'(b),
                           sub:   sub};
        end else begin : gen_src_prev
            assign src = st_q[k-1];
        end

        assign op_a = src.a[k*CHUNK +: CHUNK];
        assign op_b = src.b[k*CHUNK +: CHUNK] ^ {CHUNK{src.sub}};

        add_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a (op_a),
            .b (op_b),
            .ci(src.carry),
            .s (sum_chunk),
            .co(co)
        );

        assign res[k] = merge_chunk(src, sum_chunk, co, k);
    end

    // A stage moves when any stage from it to the output is empty, or the output drains.
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                adv[k] = adv[k] | ~st_q[j].valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    st_q[k] <= res[k];
                end
            end
        end
    end

    stage_t last;
    logic   b_eff_msb;
    logic   unused_last;

    assign last        = st_q[STAGES-1];
    assign b_eff_msb   = last.b[WIDTH-1] ^ last.sub;
    assign in_ready    = adv[0];
    assign out_valid   = last.valid;
    assign s           = last.sum[WIDTH-1:0];
    assign cout        = last.carry;
    assign ovf         = (last.a[WIDTH-1] == b_eff_msb) && (last.sum[WIDTH-1] != last.a[WIDTH-1]);
    assign unused_last = ^last;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, STAGES=4): directed vectors, back-to-back,
// full-pipeline stall, random handshake traffic and mid-flight reset.
module tb_pipe_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    pipe_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } res_t;

    res_t            exp_q [$];
    int              acc_q [$];
    int              n_checks  = 0;
    int              n_errors  = 0;
    int              cyc       = 0;
    int              n_acc     = 0;
    int              n_out     = 0;
    int              first_out = -1;
    int              last_out  = -1;
    bit              lat_chk   = 1'b0;
    bit              use_dir   = 1'b0;
    res_t            dir_res;
    bit              hold_v    = 1'b0;
    logic [WIDTH+1:0] hold;

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   t;
        res_t             r;
        be  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
        r.s = t[WIDTH-1:0];
        r.c = t[WIDTH];
        r.o = (x[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic sb);
        a   = x;
        b   = y;
        cin = ci;
        sub = sb;
    endtask

    // One clock: observe handshakes mid-cycle, cross the rising edge, return at the falling edge.
    task automatic step();
        res_t e;
        int   t;
        #1;
        if (out_valid && !out_ready) begin
            if (hold_v) check("stall_hold", {14'd0, s, cout, ovf}, {14'd0, hold});
            hold   = {s, cout, ovf};
            hold_v = 1'b1;
        end else begin
            hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                check("s", {16'd0, s}, {16'd0, e.s});
                check("cout", {31'd0, cout}, {31'd0, e.c});
                check("ovf", {31'd0, ovf}, {31'd0, e.o});
                if (lat_chk) check("latency", cyc - t + 1, STAGES);
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(use_dir ? dir_res : model(a, b, cin, sub));
            acc_q.push_back(cyc + 1);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) step();
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                            input logic sb, input logic [WIDTH-1:0] es, input logic ec,
                            input logic eo);
        set_op(x, y, ci, sb);
        dir_res.s = es;
        dir_res.c = ec;
        dir_res.o = eo;
        use_dir   = 1'b1;
        in_valid  = 1'b1;
        step();
        use_dir   = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Directed vectors, no stall
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        // Eight back-to-back operations
        n_out     = 0;
        first_out = -1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            set_op(WIDTH'(i), WIDTH'(16'h0100 * i), 1'b0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("b2b_count", n_out, 8);
        check("b2b_span", last_out - first_out, 7);

        // Output stalled with continuous input: pipeline fills to capacity then holds
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            set_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        #1;
        check("stall_accepts", n_acc, STAGES);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        // Full pipeline: accept and consume on the same edge
        out_ready = 1'b1;
        set_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b1);
        #1;
        check("full_accept_consume", {31'd0, in_ready && out_valid}, 32'd1);
        step();
        in_valid = 1'b0;
        drain();

        // Random handshake traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            set_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_op(WIDTH'(16'h1111 * (i + 1)), 16'h0F0F, 1'b1, 1'b0);
            step();
        end
        in_valid = 1'b0;
        step();
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_s", {16'd0, s}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        hold_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_out     = 0;
        for (int i = 0; i < 8; i++) step();
        check("no_stale", n_out, 0);
        lat_chk  = 1'b1;
        in_valid = 1'b1;
        set_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        drain();
        check("post_reset_count", n_out, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
